// File: rtl/input_pipeline_param.sv
// Streams word_count words from a source SRAM region to a destination region,
// applying an optional byte-order transform; tolerates a configurable read latency.
module input_pipeline_param #(
   parameter int DW     = 128,
   parameter int AW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src_base,
   input  logic [AW-1:0] dst_base,
   input  logic [AW-1:0] word_count,
   input  logic [1:0]    mode,
   output logic [AW-1:0] m1ReadAddr,
   input  logic [DW-1:0] m1ReadVal,
   output logic [AW-1:0] m2WriteAddr,
   output logic [DW-1:0] m2WriteVal,
   output logic          m2WE,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   state_t            state_q, state_d;
   logic [AW-1:0]     rd_addr_q, rd_addr_d;
   logic [AW-1:0]     rd_left_q, rd_left_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     wr_addr_q, wr_addr_d;
   logic [DW-1:0]     wr_val_q, wr_val_d;
   logic              rd_issue_q, rd_issue_d;
   logic              we_q, we_d;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [1:0]        mode_q, mode_d;
   logic              accept;

   function automatic logic [DW-1:0] xform(input logic [DW-1:0] w, input logic [1:0] m);
      logic [DW-1:0] r;
      r = w;
      case (m)
         2'b01: for (int b = 0; b < DW/8; b++) r[8*b +: 8] = w[8*(DW/8-1-b) +: 8];
         2'b10: for (int l = 0; l < DW/32; l++)
                   for (int b = 0; b < 4; b++) r[32*l + 8*b +: 8] = w[32*l + 8*(3-b) +: 8];
         default: r = w;
      endcase
      return r;
   endfunction

   assign accept = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

   always_comb begin
      state_d    = state_q;
      rd_addr_d  = rd_addr_q;
      rd_left_d  = rd_left_q;
      rd_issue_d = rd_issue_q;
      wr_ptr_d   = wr_ptr_q;
      wr_addr_d  = wr_addr_q;
      wr_val_d   = wr_val_q;
      mode_d     = mode_q;
      we_d       = 1'b0;

      // vld_q[i] set means the read issued i+1 cycles ago is still in flight
      vld_d[0] = rd_issue_q;
      for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];

      if (vld_q[RD_LAT-1]) begin
         wr_val_d  = xform(m1ReadVal, mode_q);
         wr_addr_d = wr_ptr_q;
         wr_ptr_d  = wr_ptr_q + ADDR_ONE;
         we_d      = 1'b1;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               mode_d   = mode;
               wr_ptr_d = dst_base;
               if (word_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_RUN;
                  rd_addr_d  = src_base;
                  rd_left_d  = word_count - ADDR_ONE;
                  rd_issue_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (rd_left_q != '0) begin
               rd_addr_d = rd_addr_q + ADDR_ONE;
               rd_left_d = rd_left_q - ADDR_ONE;
            end else begin
               rd_issue_d = 1'b0;
               state_d    = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Empty pipe here means the final write is already on the bus
            if (vld_q == '0) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         rd_addr_q  <= '0;
         rd_left_q  <= '0;
         rd_issue_q <= 1'b0;
         wr_ptr_q   <= '0;
         wr_addr_q  <= '0;
         wr_val_q   <= '0;
         we_q       <= 1'b0;
         vld_q      <= '0;
         mode_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         rd_left_q  <= rd_left_d;
         rd_issue_q <= rd_issue_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_addr_q  <= wr_addr_d;
         wr_val_q   <= wr_val_d;
         we_q       <= we_d;
         vld_q      <= vld_d;
         mode_q     <= mode_d;
      end
   end

   assign m1ReadAddr  = rd_addr_q;
   assign m2WriteAddr = wr_addr_q;
   assign m2WriteVal  = wr_val_q;
   assign m2WE        = we_q;
   assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_input_pipeline_param.sv
// Randomized bench for input_pipeline_param: two instances (read latency 1 and 3)
// share one source memory and are checked against a transfer-level reference model.
module tb_input_pipeline_param;

   logic          clock, rst_n, start;
   logic [15:0]   src_base, dst_base, word_count;
   logic [1:0]    mode;
   logic [15:0]   ra [2];
   logic [15:0]   wa [2];
   logic [127:0]  rv [2];
   logic [127:0]  wv [2];
   logic          we [2];
   logic          busy [2];
   logic          done [2];

   logic [127:0]  mem [65536];
   logic [15:0]   p0;
   logic [15:0]   p1 [3];

   int            n_chk = 0;
   int            n_err = 0;
   logic [127:0]  first_wv;

   input_pipeline_param #(.DW(128), .AW(16), .RD_LAT(1)) u_dut0 (
      .clock(clock), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
      .word_count(word_count), .mode(mode), .m1ReadAddr(ra[0]), .m1ReadVal(rv[0]),
      .m2WriteAddr(wa[0]), .m2WriteVal(wv[0]), .m2WE(we[0]), .busy(busy[0]), .done(done[0]));

   input_pipeline_param #(.DW(128), .AW(16), .RD_LAT(3)) u_dut1 (
      .clock(clock), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
      .word_count(word_count), .mode(mode), .m1ReadAddr(ra[1]), .m1ReadVal(rv[1]),
      .m2WriteAddr(wa[1]), .m2WriteVal(wv[1]), .m2WE(we[1]), .busy(busy[1]), .done(done[1]));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Source SRAM: data for an address appears RD_LAT cycles after it is presented
   always @(posedge clock) begin
      p0    <= ra[0];
      p1[0] <= ra[1];
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end
   assign rv[0] = mem[p0];
   assign rv[1] = mem[p1[2]];

   function automatic int lat(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic logic [127:0] xform_ref(input logic [127:0] w, input logic [1:0] m);
      logic [7:0]   by [16];
      logic [127:0] r;
      for (int b = 0; b < 16; b++) by[b] = w[8*b +: 8];
      for (int b = 0; b < 16; b++) begin
         case (m)
            2'b01:   r[8*b +: 8] = by[15 - b];
            2'b10:   r[8*b +: 8] = by[(b / 4) * 4 + (3 - b % 4)];
            default: r[8*b +: 8] = by[b];
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s u%0d rd_addr", tag, i), 128'(ra[i]), 128'd0);
         chk($sformatf("%s u%0d wr_addr", tag, i), 128'(wa[i]), 128'd0);
         chk($sformatf("%s u%0d wr_val", tag, i), wv[i], 128'd0);
         chk($sformatf("%s u%0d we", tag, i), 128'(we[i]), 128'd0);
         chk($sformatf("%s u%0d busy", tag, i), 128'(busy[i]), 128'd0);
         chk($sformatf("%s u%0d done", tag, i), 128'(done[i]), 128'd0);
      end
   endtask

   task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                           input logic [1:0] m, input bit hold);
      int          widx [2];
      int          wlast [2];
      int          dn [2];
      int          cyc;
      int          tail;
      logic [15:0] ad;
      for (int i = 0; i < 2; i++) begin
         widx[i] = 0; wlast[i] = -1; dn[i] = -1;
      end
      @(negedge clock);
      src_base = s; dst_base = d; word_count = n; mode = m; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      if (!hold) start = 1'b0;
      cyc  = 0;
      tail = -1;
      while (cyc < int'(n) + 24) begin
         for (int i = 0; i < 2; i++) begin
            if (cyc < int'(n)) begin
               ad = s + 16'(cyc);
               chk($sformatf("u%0d rd_addr k=%0d", i, cyc), 128'(ra[i]), 128'(ad));
            end
            if (cyc == 0 && n != 0) chk($sformatf("u%0d busy_run", i), 128'(busy[i]), 128'd1);
            if (we[i]) begin
               if (widx[i] < int'(n)) begin
                  ad = d + 16'(widx[i]);
                  chk($sformatf("u%0d wr_addr j=%0d", i, widx[i]), 128'(wa[i]), 128'(ad));
                  ad = s + 16'(widx[i]);
                  chk($sformatf("u%0d wr_val j=%0d", i, widx[i]), wv[i], xform_ref(mem[ad], m));
                  if (widx[i] == 0) begin
                     chk($sformatf("u%0d first_wr_lat", i), 128'(cyc), 128'(lat(i) + 1));
                     if (i == 0) first_wv = wv[i];
                  end else begin
                     chk($sformatf("u%0d wr_b2b", i), 128'(cyc), 128'(wlast[i] + 1));
                  end
               end else begin
                  chk($sformatf("u%0d extra_wr", i), 128'(widx[i]), 128'(n));
               end
               widx[i]++;
               wlast[i] = cyc;
            end
            if (done[i] && dn[i] < 0) dn[i] = cyc;
         end
         if (hold && (done[0] || done[1])) start = 1'b0;
         if (dn[0] >= 0 && dn[1] >= 0 && tail < 0) tail = cyc + 3;
         if (cyc == tail) break;
         @(negedge clock);
         cyc++;
      end
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d n_writes", i), 128'(widx[i]), 128'(n));
         if (n != 0) chk($sformatf("u%0d done_lat", i), 128'(dn[i]), 128'(wlast[i] + 1));
         else chk($sformatf("u%0d zero_done", i), 128'(dn[i] >= 0 && dn[i] <= 1), 128'd1);
         chk($sformatf("u%0d busy_end", i), 128'(busy[i]), 128'd0);
         chk($sformatf("u%0d done_end", i), 128'(done[i]), 128'd1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int          cnt;
      int          guard;
      logic [15:0] rs, rd, rn;
      logic [1:0]  rm;

      for (int a = 0; a < 65536; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
      mem[16'h0010] = 128'hAAAA_0000_1111_2222_3333_4444_5555_0001;
      mem[16'h0011] = 128'hBBBB_0000_1111_2222_3333_4444_5555_0002;
      mem[16'h0012] = 128'hCCCC_0000_1111_2222_3333_4444_5555_0003;
      mem[16'h0013] = 128'hDDDD_0000_1111_2222_3333_4444_5555_0004;
      mem[16'h0040] = 128'h000102030405060708090A0B0C0D0E0F;

      rst_n = 1'b0; start = 1'b0; src_base = '0; dst_base = '0; word_count = '0; mode = 2'b00;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk_idle_outputs("reset");
      rst_n = 1'b1;

      run_xfer(16'h0010, 16'h0100, 16'd4, 2'b00, 1'b0);
      run_xfer(16'h0040, 16'h0500, 16'd1, 2'b01, 1'b0);
      chk("mode01_word", first_wv, 128'h0F0E0D0C0B0A09080706050403020100);
      run_xfer(16'h0040, 16'h0501, 16'd1, 2'b10, 1'b0);
      chk("mode10_word", first_wv, 128'h03020100070605040B0A09080F0E0D0C);
      run_xfer(16'h0040, 16'h0502, 16'd2, 2'b11, 1'b0);
      run_xfer(16'h0020, 16'h0600, 16'd0, 2'b00, 1'b0);
      run_xfer(16'hFFFE, 16'hFFFF, 16'd3, 2'b01, 1'b0);
      run_xfer(16'h0300, 16'h0300, 16'd6, 2'b10, 1'b0);
      run_xfer(16'h0700, 16'h0800, 16'd8, 2'b00, 1'b1);

      for (int t = 0; t < 6; t++) begin
         rs = 16'($urandom); rd = 16'($urandom);
         rn = 16'($urandom_range(1, 12)); rm = 2'($urandom_range(0, 3));
         run_xfer(rs, rd, rn, rm, 1'b0);
      end

      // Abort an 8-word transfer right after the second write of the latency-1 instance
      @(negedge clock);
      src_base = 16'h0900; dst_base = 16'h0A00; word_count = 16'd8; mode = 2'b00; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      cnt = 0; guard = 0;
      while (cnt < 2 && guard < 20) begin
         if (we[0]) cnt++;
         if (cnt < 2) begin
            @(negedge clock);
            guard++;
         end
      end
      chk("abort_reached_2nd_wr", 128'(cnt), 128'd2);
      #1 rst_n = 1'b0;
      #1 chk_idle_outputs("abort");
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) chk($sformatf("u%0d we_in_reset", i), 128'(we[i]), 128'd0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d we_after_abort", i), 128'(we[i]), 128'd0);
            chk($sformatf("u%0d busy_after_abort", i), 128'(busy[i]), 128'd0);
         end
      end

      run_xfer(16'h0B00, 16'h0C00, 16'd5, 2'b10, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
